hangman_control: RTL
====================

Name: hangman_control

Overview:
- Game-sequencing FSM for the hangman datapath.
- Consumes keyboard strobes plus datapath/draw-engine status flags; drives the one-hot-per-phase enables `ld`, `ld_g`, `timecount`, `compare`, `fill`, `draw`, `over`.
- Tracks word length, miss count, winner and per-player scores.
- Sits between the keyboard decoder and the datapath; owns all phase ordering so the datapath never sees two enables at once.

Parameters:
- MAX_LEN, 16, maximum letters accepted in LOAD_WORD (1..31).
- MAX_MISS, 6, misses (body parts) that end the round as a setter win (1..7).

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-high despite the name
- key_valid  in  1  one-cycle strobe: new keyboard character available
- key_char  in  5  character code (0..25) qualified by key_valid
- key_enter  in  1  one-cycle strobe: Enter key
- compare_done  in  1  datapath finished scanning the word for the current guess
- match  in  1  guess found in word; sampled only with compare_done
- remain_zero  in  1  no unrevealed letters remain
- graph_loaded  in  1  gallows drawing complete
- finish  in  1  active draw engine (fill/parts/clear) complete
- timeout  in  1  guess timer expired
- ld, ld_g, timecount, compare, fill, draw, over  out  1 each  phase enables to datapath
- len_cnt  out  5  letters entered this round
- miss_cnt  out  3  misses this round
- p1_win, p2_win  out  1 each  round result (p1 = setter, p2 = guesser)
- p1_score, p2_score  out  4 each  cumulative scores
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: state IDLE. All outputs, counters and scores are 0.
- Reset mid-operation returns to IDLE on the next edge, drops every enable, and clears scores.
- Outputs are a Moore decode of the registered state: an enable is high for exactly the cycles the state register holds the matching state. Counters and flags are registered.
- State encodings: IDLE=0, LOAD_WORD=1, LOAD_GRAPH=2, WAIT_GUESS=3, COMPARE=4, FILL=5, DRAW=6, CHECK=7, OVER=8, DONE=9. Codes 10-15 are unused and go to IDLE.
- IDLE: key_enter -> LOAD_WORD. Clears len_cnt, miss_cnt, p1_win, p2_win.
- LOAD_WORD (ld=1):
  - Each key_valid increments len_cnt; key_valid is ignored once len_cnt==MAX_LEN.
  - key_enter with len_cnt>=1 -> LOAD_GRAPH. key_enter with len_cnt==0 is ignored.
  - key_valid and key_enter in the same cycle: the letter is counted, then the transition occurs.
- LOAD_GRAPH (ld_g=1): graph_loaded -> WAIT_GUESS.
- WAIT_GUESS (timecount=1):
  - key_valid -> COMPARE.
  - timeout -> OVER with p1_win=1. timeout wins over a simultaneous key_valid.
- COMPARE (compare=1): hold until compare_done. Then match=1 -> FILL, match=0 -> DRAW.
- FILL (fill=1): finish -> CHECK.
- DRAW (draw=1): finish -> CHECK and miss_cnt+1 on that edge.
- CHECK (exactly 1 cycle):
  - remain_zero -> OVER with p2_win=1.
  - Else miss_cnt==MAX_MISS -> OVER with p1_win=1.
  - Else -> WAIT_GUESS.
  - remain_zero has priority over the miss condition.
- OVER (over=1): finish -> DONE. The winner's score increments on the OVER->DONE edge and saturates at 15.
- DONE: p1_win/p2_win hold. key_enter -> IDLE. All other inputs are ignored.
- Status inputs arriving in states that do not expect them are ignored, including a stray finish or graph_loaded.

Optional Feature:
- Macro: HANGMAN_REPEAT_FILTER_EN.
- With the macro defined:
  - A 26-bit used-letter mask is cleared on entry to LOAD_GRAPH.
  - In WAIT_GUESS, key_valid with key_char already set in the mask is ignored (no COMPARE, no miss); otherwise the mask bit is set and the FSM moves to COMPARE.
  - key_char>25 is always ignored.
- Without the macro: key_char is unused and every key_valid in WAIT_GUESS enters COMPARE.

Test Plan:
- Reset, then key_enter, 4×key_valid, key_enter, graph_loaded -> ld high 5 cycles, len_cnt=4, ld_g high until graph_loaded, state_dbg=3.
- In WAIT_GUESS: key_valid; compare_done with match=1; finish with remain_zero=1 -> FILL, CHECK, OVER, p2_win=1; finish -> DONE with p2_score=1.
- Six misses (compare_done with match=0, then finish, each time) -> miss_cnt=6 after the 6th CHECK, p1_win=1, OVER.
- timeout and key_valid in the same cycle in WAIT_GUESS -> OVER with p1_win=1, compare never asserted.
- key_enter with len_cnt=0 -> stays LOAD_WORD; 17 key_valids -> len_cnt=16.
- Assert resetn during DRAW -> next cycle state IDLE, draw=0, scores=0. With HANGMAN_REPEAT_FILTER_EN, the same key_char guessed twice -> second guess produces no compare pulse.

Source files
------------

// File: rtl/hangman_control_if.sv
// Keyboard/status/enable bundle between the hangman sequencer and its neighbours.
// master drives keyboard strobes and datapath status; slave is the sequencer.
interface hangman_control_if;
    logic       key_valid;
    logic [4:0] key_char;
    logic       key_enter;
    logic       compare_done;
    logic       match;
    logic       remain_zero;
    logic       graph_loaded;
    logic       finish;
    logic       timeout;

    logic       ld;
    logic       ld_g;
    logic       timecount;
    logic       compare;
    logic       fill;
    logic       draw;
    logic       over;
    logic [4:0] len_cnt;
    logic [2:0] miss_cnt;
    logic       p1_win;
    logic       p2_win;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [3:0] state_dbg;

    modport master (
        output key_valid, key_char, key_enter, compare_done, match,
               remain_zero, graph_loaded, finish, timeout,
        input  ld, ld_g, timecount, compare, fill, draw, over,
               len_cnt, miss_cnt, p1_win, p2_win, p1_score, p2_score, state_dbg
    );

    modport slave (
        input  key_valid, key_char, key_enter, compare_done, match,
               remain_zero, graph_loaded, finish, timeout,
        output ld, ld_g, timecount, compare, fill, draw, over,
               len_cnt, miss_cnt, p1_win, p2_win, p1_score, p2_score, state_dbg
    );
endinterface

// File: rtl/hangman_control.sv
// Hangman game sequencer: one phase enable at a time, word length, misses, scores.
// Define HANGMAN_REPEAT_FILTER_EN to ignore letters already guessed this round.
module hangman_control #(
    parameter int MAX_LEN  = 16,
    parameter int MAX_MISS = 6
) (
    input  logic              clk,
    input  logic              resetn,
    hangman_control_if.slave  bus
);
    localparam logic [4:0] MAX_LEN_C  = 5'(MAX_LEN);
    localparam logic [2:0] MAX_MISS_C = 3'(MAX_MISS);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD_WORD  = 4'd1,
        LOAD_GRAPH = 4'd2,
        WAIT_GUESS = 4'd3,
        COMPARE    = 4'd4,
        FILL       = 4'd5,
        DRAW       = 4'd6,
        CHECK      = 4'd7,
        OVER       = 4'd8,
        DONE       = 4'd9
    } state_t;

    state_t     state_reg, state_next;
    logic [4:0] len_reg, len_next;
    logic [2:0] miss_reg, miss_next;
    logic       p1_win_reg, p1_win_next;
    logic       p2_win_reg, p2_win_next;
    logic [3:0] p1_score_reg, p1_score_next;
    logic [3:0] p2_score_reg, p2_score_next;
    logic       ld_reg, ld_g_reg, timecount_reg, compare_reg;
    logic       fill_reg, draw_reg, over_reg;
    logic       guess_ok;

`ifdef HANGMAN_REPEAT_FILTER_EN
    logic [25:0] used_reg, used_next;
    logic [25:0] char_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 26; gi++) begin : g_onehot
            assign char_onehot[gi] = (bus.key_char == 5'(gi));
        end
    endgenerate

    // An out-of-range code decodes to all zeros and is rejected outright.
    assign guess_ok = bus.key_valid && (|char_onehot) && !(|(used_reg & char_onehot));
`else
    logic unused_key_char;
    assign unused_key_char = ^bus.key_char;
    assign guess_ok        = bus.key_valid;
`endif

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        miss_next     = miss_reg;
        p1_win_next   = p1_win_reg;
        p2_win_next   = p2_win_reg;
        p1_score_next = p1_score_reg;
        p2_score_next = p2_score_reg;
`ifdef HANGMAN_REPEAT_FILTER_EN
        used_next     = used_reg;
`endif
        case (state_reg)
            IDLE: begin
                len_next    = '0;
                miss_next   = '0;
                p1_win_next = 1'b0;
                p2_win_next = 1'b0;
                if (bus.key_enter) state_next = LOAD_WORD;
            end
            LOAD_WORD: begin
                if (bus.key_valid && len_reg != MAX_LEN_C) len_next = len_reg + 5'd1;
                // A letter arriving with Enter counts toward the non-empty test.
                if (bus.key_enter && len_next != 5'd0) begin
                    state_next = LOAD_GRAPH;
`ifdef HANGMAN_REPEAT_FILTER_EN
                    used_next  = '0;
`endif
                end
            end
            LOAD_GRAPH: begin
                if (bus.graph_loaded) state_next = WAIT_GUESS;
            end
            WAIT_GUESS: begin
                if (bus.timeout) begin
                    state_next  = OVER;
                    p1_win_next = 1'b1;
                end else if (guess_ok) begin
                    state_next = COMPARE;
`ifdef HANGMAN_REPEAT_FILTER_EN
                    used_next  = used_reg | char_onehot;
`endif
                end
            end
            COMPARE: begin
                if (bus.compare_done) state_next = bus.match ? FILL : DRAW;
            end
            FILL: begin
                if (bus.finish) state_next = CHECK;
            end
            DRAW: begin
                if (bus.finish) begin
                    state_next = CHECK;
                    miss_next  = miss_reg + 3'd1;
                end
            end
            CHECK: begin
                if (bus.remain_zero) begin
                    state_next  = OVER;
                    p2_win_next = 1'b1;
                end else if (miss_reg == MAX_MISS_C) begin
                    state_next  = OVER;
                    p1_win_next = 1'b1;
                end else begin
                    state_next = WAIT_GUESS;
                end
            end
            OVER: begin
                if (bus.finish) begin
                    state_next = DONE;
                    if (p1_win_reg && p1_score_reg != 4'hF) p1_score_next = p1_score_reg + 4'd1;
                    if (p2_win_reg && p2_score_reg != 4'hF) p2_score_next = p2_score_reg + 4'd1;
                end
            end
            DONE: begin
                if (bus.key_enter) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Enables are registered from the next state so they track state_reg exactly.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            miss_reg      <= '0;
            p1_win_reg    <= 1'b0;
            p2_win_reg    <= 1'b0;
            p1_score_reg  <= '0;
            p2_score_reg  <= '0;
            ld_reg        <= 1'b0;
            ld_g_reg      <= 1'b0;
            timecount_reg <= 1'b0;
            compare_reg   <= 1'b0;
            fill_reg      <= 1'b0;
            draw_reg      <= 1'b0;
            over_reg      <= 1'b0;
`ifdef HANGMAN_REPEAT_FILTER_EN
            used_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            miss_reg      <= miss_next;
            p1_win_reg    <= p1_win_next;
            p2_win_reg    <= p2_win_next;
            p1_score_reg  <= p1_score_next;
            p2_score_reg  <= p2_score_next;
            ld_reg        <= (state_next == LOAD_WORD);
            ld_g_reg      <= (state_next == LOAD_GRAPH);
            timecount_reg <= (state_next == WAIT_GUESS);
            compare_reg   <= (state_next == COMPARE);
            fill_reg      <= (state_next == FILL);
            draw_reg      <= (state_next == DRAW);
            over_reg      <= (state_next == OVER);
`ifdef HANGMAN_REPEAT_FILTER_EN
            used_reg      <= used_next;
`endif
        end
    end

    assign bus.ld        = ld_reg;
    assign bus.ld_g      = ld_g_reg;
    assign bus.timecount = timecount_reg;
    assign bus.compare   = compare_reg;
    assign bus.fill      = fill_reg;
    assign bus.draw      = draw_reg;
    assign bus.over      = over_reg;
    assign bus.len_cnt   = len_reg;
    assign bus.miss_cnt  = miss_reg;
    assign bus.p1_win    = p1_win_reg;
    assign bus.p2_win    = p2_win_reg;
    assign bus.p1_score  = p1_score_reg;
    assign bus.p2_score  = p2_score_reg;
    assign bus.state_dbg = state_reg;
endmodule
